// File: rtl/inst_fetch.sv
// inst_fetch: ROM fetch initiator with PC, 2-entry fetch queue and decode handshake.
// Ports: clk/rst, rom_ce/rom_addr/rom_inst, id_valid/id_ready/id_pc/id_inst,
// br_valid/br_target, halt, ifault. Optional macro: IF_FAULT_CHECK_EN.
module inst_fetch #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_inst,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       id_pc,
  output logic [31:0]       id_inst,
  input  logic              br_valid,
  input  logic [31:0]       br_target,
  input  logic              halt,
  output logic              ifault
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALTED
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] q_pc   [2];
  logic [31:0] q_inst [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;
  logic        full, pop, push;
  logic        try_cap, bad, fault;

  assign rom_ce   = (state == FETCH);
  assign rom_addr = pc[ADDR_W+1:2];
  assign full     = (count == 2'd2);
  assign id_valid = (count != 2'd0);
  assign id_pc    = id_valid ? q_pc[rd_ptr]   : '0;
  assign id_inst  = id_valid ? q_inst[rd_ptr] : '0;

  // a redirect edge owns the queue: no capture, and the head is dropped
  assign try_cap = (state == FETCH) && !br_valid;
  assign pop     = id_valid && id_ready && !br_valid;
  assign push    = try_cap && !bad && (!full || pop);

`ifdef IF_FAULT_CHECK_EN
  assign bad = (pc[1:0] != 2'b00) || (pc[31:ADDR_W+2] != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fault <= 1'b0;
    else if (try_cap && bad) fault <= 1'b1;
  end
`else
  assign bad   = 1'b0;
  assign fault = 1'b0;
`endif

  assign ifault = fault;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   state_nx = FETCH;
      FETCH:  if (!br_valid && (halt || bad)) state_nx = HALTED;
      HALTED: if (!br_valid && !halt && !fault) state_nx = FETCH;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    pc_nx = pc;
    if (br_valid) pc_nx = br_target;
    else if (push) pc_nx = pc + 32'd4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        q_pc[i]   <= '0;
        q_inst[i] <= '0;
      end
    end else if (br_valid) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        q_pc[wr_ptr]   <= pc;
        q_inst[wr_ptr] <= rom_inst;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed stimulus with a scoreboard of expected handshakes.
// A negedge monitor pops and compares each accepted {pc, inst}.
module tb_inst_fetch;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rom_ce;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_inst;
  logic          id_valid;
  logic          id_ready = 1'b0;
  logic [31:0]   id_pc;
  logic [31:0]   id_inst;
  logic          br_valid = 1'b0;
  logic [31:0]   br_target = '0;
  logic          halt = 1'b0;
  logic          ifault;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];

  inst_fetch #(.ADDR_W(AW), .RESET_PC(32'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .rom_ce    (rom_ce),
    .rom_addr  (rom_addr),
    .rom_inst  (rom_inst),
    .id_valid  (id_valid),
    .id_ready  (id_ready),
    .id_pc     (id_pc),
    .id_inst   (id_inst),
    .br_valid  (br_valid),
    .br_target (br_target),
    .halt      (halt),
    .ifault    (ifault)
  );

  always #5 clk = ~clk;

  assign rom_inst = 32'h1000_0000 + {26'd0, rom_addr};

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic expect_hs(input logic [31:0] pc, input logic [31:0] inst);
    exp_q.push_back({pc, inst});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic check_reset();
    check("rst_rom_ce", {31'd0, rom_ce}, 32'd0);
    check("rst_id_valid", {31'd0, id_valid}, 32'd0);
    check("rst_id_pc", id_pc, 32'd0);
    check("rst_id_inst", id_inst, 32'd0);
    check("rst_ifault", {31'd0, ifault}, 32'd0);
    check("rst_rom_addr", {26'd0, rom_addr}, 32'd0);
  endtask

  task automatic check_drained(input string nm);
    check(nm, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  // leaves the bench in the IDLE cycle right after rst falls
  task automatic reset_dut();
    id_ready = 1'b0;
    br_valid = 1'b0;
    halt     = 1'b0;
    rst      = 1'b1;
    #1;
    check_reset();
    cyc();
    rst = 1'b0;
  endtask

  task automatic run_basic();
    id_ready = 1'b1;
    at_neg();
    check("idle_rom_ce", {31'd0, rom_ce}, 32'd0);
    check("idle_id_valid", {31'd0, id_valid}, 32'd0);
    cyc();
    at_neg();
    check("fetch_rom_ce", {31'd0, rom_ce}, 32'd1);
    check("fetch_id_valid", {31'd0, id_valid}, 32'd0);
    for (int i = 0; i < 4; i++)
      expect_hs(32'(i * 4), 32'h1000_0000 + 32'(i));
    cyc();
    at_neg();
    check("first_valid", {31'd0, id_valid}, 32'd1);
    check("first_pc", id_pc, 32'd0);
    check("first_inst", id_inst, 32'h1000_0000);
    check("first_rom_addr", {26'd0, rom_addr}, 32'd1);
    repeat (4) cyc();
    id_ready = 1'b0;
    at_neg();
    check_drained("basic_drained");
  endtask

  always @(negedge clk) begin
    if (!rst && id_valid && id_ready && !br_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected: got pc %h inst %h expected none",
                 id_pc, id_inst);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_pc", id_pc, e.pc);
        check("sb_inst", id_inst, e.inst);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    check_reset();
    cyc();

    // reset release with decode always ready
    reset_dut();
    run_basic();

    // backpressure: queue saturates, then drains in order
    reset_dut();
    cyc();
    cyc();
    at_neg();
    check("bp_valid", {31'd0, id_valid}, 32'd1);
    check("bp_pc0", id_pc, 32'd0);
    repeat (4) cyc();
    at_neg();
    check("bp_pc_hold", {26'd0, rom_addr}, 32'd2);
    check("bp_head", id_pc, 32'd0);
    expect_hs(32'd0, 32'h1000_0000);
    expect_hs(32'd4, 32'h1000_0001);
    expect_hs(32'd8, 32'h1000_0002);
    cyc();
    id_ready = 1'b1;
    repeat (3) cyc();
    id_ready = 1'b0;
    at_neg();
    check_drained("bp_drained");
    check("full_valid", {31'd0, id_valid}, 32'd1);
    check("full_head", id_pc, 32'd12);

    // asynchronous reset with a full queue, between clock edges
    #2;
    rst = 1'b1;
    #1;
    check_reset();
    cyc();
    rst = 1'b0;
    run_basic();

    // redirect while full: 0x10/0x14 are dropped
    reset_dut();
    cyc();
    br_valid  = 1'b1;
    br_target = 32'h10;
    cyc();
    br_valid = 1'b0;
    at_neg();
    check("br1_valid", {31'd0, id_valid}, 32'd0);
    check("br1_addr", {26'd0, rom_addr}, 32'd4);
    cyc();
    cyc();
    at_neg();
    check("br_full_valid", {31'd0, id_valid}, 32'd1);
    check("br_full_head", id_pc, 32'h10);
    check("br_full_addr", {26'd0, rom_addr}, 32'd6);
    cyc();
    id_ready  = 1'b1;
    br_valid  = 1'b1;
    br_target = 32'h40;
    cyc();
    br_valid = 1'b0;
    at_neg();
    check("br2_flushed", {31'd0, id_valid}, 32'd0);
    expect_hs(32'h40, 32'h1000_0010);
    cyc();
    at_neg();
    check("br2_pc", id_pc, 32'h40);
    cyc();
    id_ready = 1'b0;
    at_neg();
    check_drained("br_drained");

    // halt: capture at the halt edge, drain, resume at frozen pc
    reset_dut();
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      expect_hs(32'(i * 4), 32'h1000_0000 + 32'(i));
    cyc();
    cyc();
    cyc();
    halt = 1'b1;
    cyc();
    at_neg();
    check("halt_rom_ce", {31'd0, rom_ce}, 32'd0);
    cyc();
    at_neg();
    check("halt_empty", {31'd0, id_valid}, 32'd0);
    cyc();
    at_neg();
    check("halt_empty2", {31'd0, id_valid}, 32'd0);
    check("halt_pc", {26'd0, rom_addr}, 32'd3);
    cyc();
    halt = 1'b0;
    at_neg();
    check("halt_still", {31'd0, rom_ce}, 32'd0);
    cyc();
    at_neg();
    check("resume_ce", {31'd0, rom_ce}, 32'd1);
    check("resume_valid", {31'd0, id_valid}, 32'd0);
    cyc();
    cyc();
    id_ready = 1'b0;
    at_neg();
    check_drained("halt_drained");

    // misaligned / out-of-range target 0x102
    reset_dut();
    cyc();
    br_valid  = 1'b1;
    br_target = 32'h102;
    cyc();
    br_valid = 1'b0;
    at_neg();
    check("mis_addr", {26'd0, rom_addr}, 32'd0);
`ifdef IF_FAULT_CHECK_EN
    cyc();
    id_ready = 1'b1;
    at_neg();
    check("flt_ifault", {31'd0, ifault}, 32'd1);
    check("flt_rom_ce", {31'd0, rom_ce}, 32'd0);
    check("flt_valid", {31'd0, id_valid}, 32'd0);
    cyc();
    at_neg();
    check("flt_valid2", {31'd0, id_valid}, 32'd0);
    id_ready = 1'b0;
    check_drained("flt_drained");
`else
    expect_hs(32'h102, 32'h1000_0000);
    expect_hs(32'h106, 32'h1000_0001);
    cyc();
    id_ready = 1'b1;
    cyc();
    cyc();
    id_ready = 1'b0;
    at_neg();
    check_drained("mis_drained");
    check("mis_ifault", {31'd0, ifault}, 32'd0);

    // pc wrap 0xFFFF_FFFC -> 0
    reset_dut();
    cyc();
    br_valid  = 1'b1;
    br_target = 32'hFFFF_FFFC;
    cyc();
    br_valid = 1'b0;
    at_neg();
    check("wrap_addr", {26'd0, rom_addr}, 32'd63);
    expect_hs(32'hFFFF_FFFC, 32'h1000_003F);
    expect_hs(32'h0, 32'h1000_0000);
    cyc();
    id_ready = 1'b1;
    at_neg();
    check("wrap_addr0", {26'd0, rom_addr}, 32'd0);
    cyc();
    cyc();
    id_ready = 1'b0;
    at_neg();
    check_drained("wrap_drained");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
